ts_rcv: RTL and testbench

- Per-lane training-sequence receiver. Decodes, validates and qualifies the 128-bit TS1/TS2 words that the partner's TS generator delivers.
- Tracks runs of consecutive identical TS and reports decoded fields, run count and threshold match to core_fsm.
- One instance per lane (lane0..lane3), sitting between the lane TS input and core_fsm.

---
 rtl/ltssm_pkg.sv | 47 ++++
 rtl/ts_decode.sv | 36 +++
 rtl/ts_rcv.sv | 133 +++++++++++++
 tb/tb_ts_rcv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: TS symbol constants, symbol indices,
// TS type and receiver state encodings, decoded field bundle.
package ltssm_pkg;

   localparam logic [7:0] COM    = 8'hBC;
   localparam logic [7:0] TS1_ID = 8'h4A;
   localparam logic [7:0] TS2_ID = 8'h45;
   localparam logic [7:0] PAD    = 8'hF7;

   localparam int SYM_LINK  = 1;
   localparam int SYM_LANE  = 2;
   localparam int SYM_NFTS  = 3;
   localparam int SYM_RATE  = 4;
   localparam int SYM_CTRL  = 5;
   localparam int SYM_ID_LO = 6;
   localparam int NUM_SYM   = 16;

   localparam int TMO_W = 16;

   typedef enum logic [1:0] {
      TS_NONE = 2'b00,
      TS_T1   = 2'b01,
      TS_T2   = 2'b10
   } ts_type_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'b00,
      RX_RUN   = 2'b01,
      RX_MATCH = 2'b10
   } rx_state_e;

   typedef struct packed {
      logic [7:0] link;
      logic [7:0] lane;
      logic [7:0] nfts;
      logic [7:0] rate;
      logic [7:0] ctrl;
   } ts_fields_t;

   function automatic logic [7:0] ts_sym(
      input logic [127:0] ts,
      input int           k
   );
      return ts[8*k +: 8];
   endfunction

endpackage

// File: rtl/ts_decode.sv
// Combinational TS format check and field extraction.
// Ports: ts (128-bit word in), well_formed, ts_type, fields (out).
module ts_decode
   import ltssm_pkg::*;
(
   input  logic [127:0] ts,
   output logic         well_formed,
   output ts_type_e     ts_type,
   output ts_fields_t   fields
);

   logic [7:0] id;
   logic       ids_eq;

   always_comb begin
      id     = ts_sym(ts, SYM_ID_LO);
      ids_eq = 1'b1;
      for (int k = SYM_ID_LO + 1; k < NUM_SYM; k++) begin
         if (ts_sym(ts, k) != id) ids_eq = 1'b0;
      end
      ts_type = TS_NONE;
      unique case (1'b1)
         (id == TS1_ID): ts_type = TS_T1;
         (id == TS2_ID): ts_type = TS_T2;
         default:        ts_type = TS_NONE;
      endcase
      well_formed = (ts_sym(ts, 0) == COM) && ids_eq &&
                    (ts_type != TS_NONE);
      fields.link = ts_sym(ts, SYM_LINK);
      fields.lane = ts_sym(ts, SYM_LANE);
      fields.nfts = ts_sym(ts, SYM_NFTS);
      fields.rate = ts_sym(ts, SYM_RATE);
      fields.ctrl = ts_sym(ts, SYM_CTRL);
   end

endmodule

// File: rtl/ts_rcv.sv
// Per-lane TS receiver: validates TS words, tracks identical runs.
// Ports: clk, rst, ts_i/ts_i_vld, ts_clr in; rx_* fields/pulses,
// consec_cnt and ts_match out, all registered.
module ts_rcv
   import ltssm_pkg::*;
#(
   parameter int MATCH_CNT   = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [127:0]     ts_i,
   input  logic             ts_i_vld,
   input  logic             ts_clr,
   output logic             rx_vld,
   output logic [1:0]       rx_type,
   output logic [7:0]       rx_link,
   output logic [7:0]       rx_lane,
   output logic [7:0]       rx_nfts,
   output logic [7:0]       rx_rate,
   output logic [7:0]       rx_ctrl,
   output logic [CNT_W-1:0] consec_cnt,
   output logic             ts_match,
   output logic             rx_err,
   output logic             rx_timeout
);

   localparam logic [CNT_W-1:0] MATCH_V = CNT_W'(MATCH_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Counter value one edge before it would read TIMEOUT_CYC-1.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

   logic       dec_ok;
   ts_type_e   dec_type;
   ts_fields_t dec_f;

   ts_decode u_dec (
      .ts          (ts_i),
      .well_formed (dec_ok),
      .ts_type     (dec_type),
      .fields      (dec_f)
   );

   rx_state_e        state, state_nxt;
   logic [119:0]     ref_q, ref_nxt;
   logic [TMO_W-1:0] tmo_q, tmo_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             vld_nxt, err_nxt, tmo_p_nxt;
   logic             upd;
   logic             same;

   assign same = (ts_i[127:8] == ref_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RX_IDLE;
         ref_q      <= '0;
         tmo_q      <= '0;
         consec_cnt <= '0;
         ts_match   <= 1'b0;
         rx_vld     <= 1'b0;
         rx_err     <= 1'b0;
         rx_timeout <= 1'b0;
         rx_type    <= 2'b00;
         rx_link    <= '0;
         rx_lane    <= '0;
         rx_nfts    <= '0;
         rx_rate    <= '0;
         rx_ctrl    <= '0;
      end else begin
         state      <= state_nxt;
         ref_q      <= ref_nxt;
         tmo_q      <= tmo_nxt;
         consec_cnt <= cnt_nxt;
         ts_match   <= (state_nxt == RX_MATCH);
         rx_vld     <= vld_nxt;
         rx_err     <= err_nxt;
         rx_timeout <= tmo_p_nxt;
         if (upd) begin
            rx_type <= dec_type;
            rx_link <= dec_f.link;
            rx_lane <= dec_f.lane;
            rx_nfts <= dec_f.nfts;
            rx_rate <= dec_f.rate;
            rx_ctrl <= dec_f.ctrl;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ref_nxt   = ref_q;
      tmo_nxt   = tmo_q;
      cnt_nxt   = consec_cnt;
      vld_nxt   = 1'b0;
      err_nxt   = 1'b0;
      tmo_p_nxt = 1'b0;
      upd       = 1'b0;
      if (ts_clr) begin
         state_nxt = RX_IDLE;
         cnt_nxt   = '0;
         tmo_nxt   = '0;
      end else if (ts_i_vld) begin
         tmo_nxt = '0;
         if (dec_ok) begin
            vld_nxt = 1'b1;
            upd     = 1'b1;
            ref_nxt = ts_i[127:8];
            if (state != RX_IDLE && same) begin
               if (consec_cnt != CNT_MAX) cnt_nxt = consec_cnt + 1'b1;
            end else begin
               cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state_nxt = (cnt_nxt >= MATCH_V) ? RX_MATCH : RX_RUN;
         end else begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RX_IDLE;
         end
      end else if (state != RX_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            tmo_p_nxt = 1'b1;
            tmo_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = RX_IDLE;
         end else begin
            tmo_nxt = tmo_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ts_rcv.sv
// Directed self-checking bench for ts_rcv.
// Drives hand-built TS words and compares registered outputs.
module tb_ts_rcv;
   import ltssm_pkg::*;

   localparam int MATCH_CNT   = 8;
   localparam int TIMEOUT_CYC = 1024;
   localparam int CNT_W       = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [127:0]     ts_i;
   logic             ts_i_vld;
   logic             ts_clr;
   logic             rx_vld;
   logic [1:0]       rx_type;
   logic [7:0]       rx_link, rx_lane, rx_nfts, rx_rate, rx_ctrl;
   logic [CNT_W-1:0] consec_cnt;
   logic             ts_match, rx_err, rx_timeout;

   int checks = 0;
   int errors = 0;

   ts_rcv #(
      .MATCH_CNT   (MATCH_CNT),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ts_i       (ts_i),
      .ts_i_vld   (ts_i_vld),
      .ts_clr     (ts_clr),
      .rx_vld     (rx_vld),
      .rx_type    (rx_type),
      .rx_link    (rx_link),
      .rx_lane    (rx_lane),
      .rx_nfts    (rx_nfts),
      .rx_rate    (rx_rate),
      .rx_ctrl    (rx_ctrl),
      .consec_cnt (consec_cnt),
      .ts_match   (ts_match),
      .rx_err     (rx_err),
      .rx_timeout (rx_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_ts(
      input logic [7:0] id, input logic [7:0] link,
      input logic [7:0] lane, input logic [7:0] nfts,
      input logic [7:0] rate, input logic [7:0] ctrl);
      logic [127:0] w;
      w = '0;
      w[7:0]   = COM;
      w[15:8]  = link;
      w[23:16] = lane;
      w[31:24] = nfts;
      w[39:32] = rate;
      w[47:40] = ctrl;
      for (int k = 6; k < 16; k++) w[8*k +: 8] = id;
      return w;
   endfunction

   task automatic send(input logic [127:0] w);
      @(negedge clk);
      ts_i     = w;
      ts_i_vld = 1'b1;
      @(posedge clk);
      #1;
      ts_i_vld = 1'b0;
   endtask

   task automatic clr_pulse(input logic with_vld, input logic [127:0] w);
      @(negedge clk);
      ts_clr   = 1'b1;
      ts_i     = w;
      ts_i_vld = with_vld;
      @(posedge clk);
      #1;
      ts_clr   = 1'b0;
      ts_i_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [127:0] t1a, t1b, t2, bad;
   int k;
   logic seen;

   initial begin
      t1a = mk_ts(TS1_ID, PAD, PAD, 8'h10, 8'h02, 8'h00);
      t1b = mk_ts(TS1_ID, PAD, 8'h01, 8'h10, 8'h02, 8'h00);
      t2  = mk_ts(TS2_ID, PAD, 8'h01, 8'h20, 8'h02, 8'h00);
      bad = t2;
      bad[79:72] = TS1_ID;

      rst = 1'b1; ts_clr = 1'b0; ts_i_vld = 1'b0; ts_i = '0;
      idle(3);
      chk("rst_vld", rx_vld, 0);
      chk("rst_type", rx_type, 0);
      chk("rst_link", rx_link, 0);
      chk("rst_cnt", consec_cnt, 0);
      chk("rst_match", ts_match, 0);
      chk("rst_err", rx_err, 0);
      chk("rst_tmo", rx_timeout, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 1; i <= 8; i++) begin
         send(t1a);
         chk("run8_vld", rx_vld, 1);
         chk("run8_cnt", consec_cnt, i);
         chk("run8_match", ts_match, (i == 8) ? 1 : 0);
         idle(1);
         chk("run8_pulse", rx_vld, 0);
         idle(62);
      end
      chk("run8_type", rx_type, 1);
      chk("run8_link", rx_link, 8'hF7);
      chk("run8_lane", rx_lane, 8'hF7);
      chk("run8_rate", rx_rate, 8'h02);
      chk("run8_nfts", rx_nfts, 8'h10);

      clr_pulse(1'b0, t1a);
      chk("clr_cnt", consec_cnt, 0);
      chk("clr_match", ts_match, 0);
      chk("clr_hold", rx_link, 8'hF7);
      for (int i = 0; i < 5; i++) begin
         send(t1a);
         idle(4);
      end
      chk("run5_cnt", consec_cnt, 5);
      send(t1b);
      chk("new_cnt", consec_cnt, 1);
      chk("new_match", ts_match, 0);
      chk("new_lane", rx_lane, 8'h01);
      for (int i = 0; i < 6; i++) send(t1b);
      chk("new7_cnt", consec_cnt, 7);
      chk("new7_match", ts_match, 0);
      send(t1b);
      chk("new8_cnt", consec_cnt, 8);
      chk("new8_match", ts_match, 1);

      send(bad);
      chk("bad_err", rx_err, 1);
      chk("bad_vld", rx_vld, 0);
      chk("bad_cnt", consec_cnt, 0);
      chk("bad_match", ts_match, 0);
      chk("bad_type", rx_type, 1);
      chk("bad_lane", rx_lane, 8'h01);
      idle(1);
      chk("bad_pulse", rx_err, 0);
      send(t2);
      chk("ts2_vld", rx_vld, 1);
      chk("ts2_err", rx_err, 0);
      chk("ts2_cnt", consec_cnt, 1);
      chk("ts2_type", rx_type, 2);
      chk("ts2_nfts", rx_nfts, 8'h20);

      send(t2);
      send(t2);
      chk("tmo_pre", consec_cnt, 3);
      k = 0;
      seen = 1'b0;
      while (k < 2000 && !seen) begin
         @(posedge clk);
         #1;
         k++;
         if (rx_timeout) seen = 1'b1;
      end
      chk("tmo_seen", seen, 1);
      chk("tmo_dist", k, TIMEOUT_CYC - 1);
      chk("tmo_cnt", consec_cnt, 0);
      chk("tmo_match", ts_match, 0);
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (rx_timeout) seen = 1'b1;
      end
      chk("idle_no_tmo", seen, 0);

      send(t2);
      idle(TIMEOUT_CYC - 2);
      send(t2);
      chk("exp_tmo", rx_timeout, 0);
      chk("exp_vld", rx_vld, 1);
      chk("exp_cnt", consec_cnt, 2);
      idle(1);
      chk("exp_tmo2", rx_timeout, 0);

      for (int i = 0; i < 6; i++) send(t2);
      chk("m_match", ts_match, 1);
      clr_pulse(1'b1, t2);
      chk("cv_vld", rx_vld, 0);
      chk("cv_err", rx_err, 0);
      chk("cv_cnt", consec_cnt, 0);
      chk("cv_match", ts_match, 0);

      @(negedge clk);
      ts_i     = t1a;
      ts_i_vld = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (i == 1)   chk("b2b_c1", consec_cnt, 1);
         if (i == 7)   chk("b2b_m7", ts_match, 0);
         if (i == 8)   chk("b2b_m8", ts_match, 1);
         if (i == 255) chk("b2b_c255", consec_cnt, 255);
         if (i == 256) chk("b2b_c256", consec_cnt, 255);
         if (i == 300) begin
            chk("b2b_c300", consec_cnt, 255);
            chk("b2b_m300", ts_match, 1);
            chk("b2b_vld", rx_vld, 1);
         end
      end
      ts_i_vld = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
